// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register and register-file write port; define WB_INSTRET_EN to add the 64-bit instret counter
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_result_sel,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_pc_plus4,
  input  logic [XLEN-1:0] mem_imm,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
`ifdef WB_INSTRET_EN
  output logic            wb_valid,
  output logic [63:0]     instret
`else
  output logic            wb_valid
`endif
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic [1:0]      load_off;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_value;
  logic [XLEN-1:0] wb_result;
  logic            write_en_next;

  assign load_off      = mem_alu_result[1:0];
  assign write_en_next = mem_valid & mem_reg_write & (mem_rd != 5'd0);

  // Pick the addressed byte/halfword lane (little-endian) and extend it by funct3.
  always_comb begin
    load_byte = mem_load_data[7:0];
    case (load_off)
      2'd1:    load_byte = mem_load_data[15:8];
      2'd2:    load_byte = mem_load_data[23:16];
      2'd3:    load_byte = mem_load_data[31:24];
      default: load_byte = mem_load_data[7:0];
    endcase
    load_half = load_off[1] ? mem_load_data[31:16] : mem_load_data[15:0];
    case (mem_funct3)
      3'b000:  load_value = {{(XLEN-8){load_byte[7]}}, load_byte};
      3'b100:  load_value = {{(XLEN-8){1'b0}}, load_byte};
      3'b001:  load_value = {{(XLEN-16){load_half[15]}}, load_half};
      3'b101:  load_value = {{(XLEN-16){1'b0}}, load_half};
      default: load_value = mem_load_data;
    endcase
  end

  // Final write-back value selection on the MEM side of the register.
  always_comb begin
    case (mem_result_sel)
      SEL_ALU:  wb_result = mem_alu_result;
      SEL_LOAD: wb_result = load_value;
      SEL_PC4:  wb_result = mem_pc_plus4;
      default:  wb_result = mem_imm;
    endcase
  end

  // MEM/WB register: flush squashes, stall holds everything, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      rf_we    <= 1'b0;
    end else if (!stall) begin
      wb_valid <= mem_valid;
      rf_we    <= write_en_next;
      rf_waddr <= mem_rd;
      rf_wdata <= wb_result;
    end
  end

`ifdef WB_INSTRET_EN
  // Count every valid entry actually captured; wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= 64'd0;
    end else if (mem_valid && !flush && !stall) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed-vector self-checking bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_result_sel;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_pc_plus4;
  logic [31:0] mem_imm;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_valid;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_result_sel (mem_result_sel),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_funct3     (mem_funct3),
    .mem_pc_plus4   (mem_pc_plus4),
    .mem_imm        (mem_imm),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
`ifdef WB_INSTRET_EN
    .wb_valid       (wb_valid),
    .instret        (instret)
`else
    .wb_valid       (wb_valid)
`endif
  );

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [2:0] f3,
                       input logic [31:0] pc4, input logic [31:0] imm);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_rd         = rd;
    mem_result_sel = sel;
    mem_alu_result = alu;
    mem_load_data  = ld;
    mem_funct3     = f3;
    mem_pc_plus4   = pc4;
    mem_imm        = imm;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [38:0] obs;
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 3'b010, 32'h0, 32'h0);
    step();
    step();
    obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", obs, 39'd0);
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 5'd7, 2'b00, 32'h0000_00A5, 32'h0, 3'b010, 32'h0, 32'h0);
    step();
    obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs !== {1'b1, 1'b1, 5'd7, 32'h0000_00A5}) begin
      miscompares++;
      $display("FAIL reset_pre_capture: got %h expected %h", obs, {1'b1, 1'b1, 5'd7, 32'h0000_00A5});
    end
    #4;
    rst_n = 1'b0;
    #1;
    obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_async_assert: got %h expected %h", obs, 39'd0);
    end
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 5'd7, 2'b00, 32'h0000_00A5, 32'h0, 3'b010, 32'h0, 32'h0);
    step();
    obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs[38:37] !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release_no_write: got valid/we %b expected 00", obs[38:37]);
    end
  endtask

  task automatic test_load_extract;
    logic [2:0]  f3  [12] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b101, 3'b001,
                              3'b101, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [1:0]  off [12] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2,
                              2'd0, 2'd1, 2'd3, 2'd1, 2'd3};
    logic [31:0] dat [12] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01,
                              32'h80FF7F01, 32'h8001ABCD, 32'h8001ABCD, 32'h8001ABCD,
                              32'h8001ABCD, 32'h8001ABCD, 32'h12345678, 32'h80FF7F01};
    logic [31:0] exp [12] = '{32'hFFFFFF80, 32'hFFFFFFFF, 32'h0000007F, 32'h00000001,
                              32'h000000FF, 32'h00008001, 32'hFFFF8001, 32'h0000ABCD,
                              32'hFFFFABCD, 32'h8001ABCD, 32'h12345678, 32'h00000080};
    logic [38:0] obs;
    logic [38:0] want;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 5'd5, 2'b01, {30'h3FFF_FF00, off[i]}, dat[i], f3[i], 32'h0, 32'h0);
      step();
      obs  = {wb_valid, rf_we, rf_waddr, rf_wdata};
      want = {1'b1, 1'b1, 5'd5, exp[i]};
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL load_extract[%0d]: got %h expected %h", i, obs, want);
      end
    end
  endtask

  task automatic test_result_sel;
    logic [38:0] obs;
    drive(1'b1, 1'b1, 5'd10, 2'b00, 32'hCAFE_0001, 32'h1111_1111, 3'b010, 32'h2222_2222, 32'h3333_3000);
    step();
    obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs !== {1'b1, 1'b1, 5'd10, 32'hCAFE_0001}) begin
      miscompares++;
      $display("FAIL sel_alu: got %h expected %h", obs, {1'b1, 1'b1, 5'd10, 32'hCAFE_0001});
    end
    mem_result_sel = 2'b10;
    mem_rd         = 5'd11;
    step();
    obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs !== {1'b1, 1'b1, 5'd11, 32'h2222_2222}) begin
      miscompares++;
      $display("FAIL sel_pc4: got %h expected %h", obs, {1'b1, 1'b1, 5'd11, 32'h2222_2222});
    end
    mem_result_sel = 2'b11;
    mem_rd         = 5'd31;
    step();
    obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs !== {1'b1, 1'b1, 5'd31, 32'h3333_3000}) begin
      miscompares++;
      $display("FAIL sel_imm: got %h expected %h", obs, {1'b1, 1'b1, 5'd31, 32'h3333_3000});
    end
  endtask

  task automatic test_write_enable;
    logic [38:0] obs;
    drive(1'b1, 1'b1, 5'd0, 2'b00, 32'h0000_1234, 32'h0, 3'b010, 32'h0, 32'h0);
    step();
    obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs[38:37] !== 2'b10) begin
      miscompares++;
      $display("FAIL x0_suppress: got valid/we %b expected 10", obs[38:37]);
    end
    drive(1'b1, 1'b0, 5'd3, 2'b00, 32'h0000_0042, 32'h0, 3'b010, 32'h0, 32'h0);
    step();
    obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs[38:37] !== 2'b10) begin
      miscompares++;
      $display("FAIL no_reg_write: got valid/we %b expected 10", obs[38:37]);
    end
    drive(1'b0, 1'b1, 5'd3, 2'b00, 32'h0000_0042, 32'h0, 3'b010, 32'h0, 32'h0);
    step();
    obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs[38:37] !== 2'b00) begin
      miscompares++;
      $display("FAIL bubble: got valid/we %b expected 00", obs[38:37]);
    end
  endtask

  task automatic test_stall_flush;
    logic [38:0] obs;
    logic [38:0] want;
    drive(1'b1, 1'b1, 5'd1, 2'b10, 32'h0000_0BAD, 32'h0, 3'b010, 32'h0000_0104, 32'h0);
    step();
    want = {1'b1, 1'b1, 5'd1, 32'h0000_0104};
    obs  = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL jal_capture: got %h expected %h", obs, want);
    end
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h0000_DEAD, 32'h0, 3'b010, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, want);
      end
    end
    flush = 1'b1;
    step();
    obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs[38:37] !== 2'b00) begin
      miscompares++;
      $display("FAIL stall_and_flush: got valid/we %b expected 00", obs[38:37]);
    end
    stall = 1'b0;
    step();
    obs = {wb_valid, rf_we, rf_waddr, rf_wdata};
    vectors++;
    if (obs[38:37] !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_only: got valid/we %b expected 00", obs[38:37]);
    end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [38:0] obs;
    logic [38:0] want;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'(i + 20), 2'b00, 32'h1000_0000 + 32'(i), 32'h0, 3'b010, 32'h0, 32'h0);
      step();
      want = {1'b1, 1'b1, 5'(i + 20), 32'h1000_0000 + 32'(i)};
      obs  = {wb_valid, rf_we, rf_waddr, rf_wdata};
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, want);
      end
    end
  endtask

`ifdef WB_INSTRET_EN
  task automatic test_instret;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 3'b010, 32'h0, 32'h0);
    step();
    vectors++;
    if (instret !== 64'd0) begin
      miscompares++;
      $display("FAIL instret_reset: got %0d expected 0", instret);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 5'd4, 2'b00, 32'(i), 32'h0, 3'b010, 32'h0, 32'h0);
      if (i == 2 || i == 5) begin
        stall = 1'b1;
        step();
        stall = 1'b0;
      end
      if (i == 7) flush = 1'b1;
      step();
      flush = 1'b0;
    end
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 3'b010, 32'h0, 32'h0);
    step();
    vectors++;
    if (instret !== 64'd9) begin
      miscompares++;
      $display("FAIL instret_count: got %0d expected 9", instret);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_extract();
    test_result_sel();
    test_write_enable();
    test_stall_flush();
    test_back_to_back();
`ifdef WB_INSTRET_EN
    test_instret();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
